fpu_result_queue: RTL and testbench
===================================

# fpu_result_queue

Downstream capture stage for the FPU core. It samples the core's combinational result bus (result, exception flags, operation tag, illegal-op), converts each new result into a single queue entry and holds entries in a small FIFO. Firmware drains the FIFO through the register/LA read path, so back-to-back operations are not lost when reads lag. It also keeps sticky accumulated exception flags (fflags) and raises a level interrupt while results are pending.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- TAG_W, 13: operation tag width ({valid_out[10:0], op_out[1:0]} of the core).
- clk  in  1  core clock.
- rst_l  in  1  asynchronous active-low reset.
- res_valid  in  1  level; high while the core drives a valid result (OR of the result-select terms).
- res_data  in  32  core result.
- res_exc  in  5  core exceptions {NV,DZ,OF,UF,NX}.
- res_tag  in  TAG_W  operation tag.
- res_illegal  in  1  core illegal_op.
- pop  in  1  one-cycle pulse; removes head entry.
- clr_flags  in  1  one-cycle pulse; clears sticky fflags and overflow.
- irq_en  in  1  interrupt enable.
- head_data  out  32  head entry result.
- head_exc  out  5  head entry exceptions.
- head_tag  out  TAG_W  head entry tag.
- head_illegal  out  1  head entry illegal flag.
- empty  out  1  queue empty.
- full  out  1  queue full.
- count  out  $clog2(DEPTH)+1  occupancy.
- fflags  out  5  sticky OR of exceptions of all accepted entries.
- overflow  out  1  sticky; an entry was dropped because the queue was full.
- irq  out  1  irq_en & ~empty.

## Operation
- Capture: push request = res_valid & ~res_valid_q (rising edge; res_valid_q registered, reset 0). A level held high for many cycles produces one entry. res_illegal high on that edge also produces an entry (push = edge of res_valid | res_illegal).
- Entry = {illegal, tag, exc, data}; when illegal, data and exc are stored as 0.
- Storage: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH; count holds the extra bit so full = (count == DEPTH).
- Push accepted if ~full, or if full and pop occurs in the same cycle (simultaneous push+pop at full: both happen, count unchanged).
- Push when full without pop: entry dropped, overflow←1, fflags not updated.
- Pop when empty: ignored, no pointer or count change.
- Push+pop when empty: push accepted, pop ignored (count becomes 1).
- fflags: on an accepted push, fflags ← fflags | exc. clr_flags clears fflags and overflow. clr_flags and an accepted push in the same cycle: fflags ← exc of the new entry, overflow ← 0. clr_flags has no effect on queue contents.
- Head outputs show the entry at rd_ptr. They are 0 when empty.

## Timing
- Reset (async assert, sync release): pointers, count, res_valid_q, fflags, overflow = 0; empty=1, full=0, irq=0, all head_* = 0. Storage contents are don't-care.
- Latency: res_valid rising in cycle N → push registered at edge end of N → head_*/count/empty/fflags reflect it in cycle N+1.
- pop in cycle N → next entry (or empty) visible in cycle N+1.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Reset asserted mid-operation discards all entries and flags immediately.

## Structure
- Shared package fpu_pkg: exception bit index constants (NV=4, DZ=3, OF=2, UF=1, NX=0), TAG_W default, and typedef struct packed fpu_result_t {illegal, tag, exc, data}.
- One sub-module: fpu_result_buf (DEPTH×entry register array with write port and registered read pointer). Edge detect, pointer/count, and sticky logic stay in the top. Use the codebase rvdff flops for the single-bit state.

## Test plan
- After reset, drive res_valid=1 for 5 cycles, res_data=32'h3F80_0000, res_exc=5'b00001 → exactly one entry; head_data=3F800000 in cycle N+1, count=1, fflags=00001, irq=1 with irq_en=1.
- Issue 5 distinct results (pulses) with DEPTH=4 and no pops → count=4, full=1, overflow=1, fifth entry absent. Pop 4 times → data appears in order 1..4, then empty=1 and head_*=0.
- Fill to full, then drive a push edge in the same cycle as pop → count stays 4, new entry ends up at the tail, overflow stays 0.
- res_illegal edge with res_data=32'hDEAD_BEEF → entry has illegal=1, data=0, exc=0.
- Accumulate exc 10000 then 00100 → fflags=10100. Then clr_flags together with a push of exc 00010 → fflags=00010.
- Pop on empty, and assert rst_l low mid-fill with 3 entries → count=0, empty=1, fflags=0 asynchronously; no underflow corruption afterwards (next push yields count=1).

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants and result entry type
package fpu_pkg;

    // Exception flag bit positions within the 5-bit {NV,DZ,OF,UF,NX} vector
    localparam int EXC_NV = 4;
    localparam int EXC_DZ = 3;
    localparam int EXC_OF = 2;
    localparam int EXC_UF = 1;
    localparam int EXC_NX = 0;

    // Default operation tag width: {valid_out[10:0], op_out[1:0]}
    localparam int FPU_TAG_W = 13;

    typedef struct packed {
        logic                 illegal;
        logic [FPU_TAG_W-1:0] tag;
        logic [4:0]           exc;
        logic [31:0]          data;
    } fpu_result_t;

endpackage

// File: rtl/fpu_result_buf.sv
// rtl/fpu_result_buf.sv - entry storage array with one write and one read port
module fpu_result_buf #(
    parameter int DEPTH = 4,
    parameter int W     = 51,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [PW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage is not reset; the top masks head outputs while the queue is empty
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // raddr comes from the registered read pointer, so rdata depends only on state
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rvdff.sv
// rtl/rvdff.sv - generic flop with asynchronous active-low reset to zero
module rvdff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Plain state flop; cleared immediately when rst_l falls
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) dout <= '0;
        else        dout <= din;
    end

endmodule

// File: rtl/fpu_result_queue.sv
// rtl/fpu_result_queue.sv - captures FPU results into a small FIFO with sticky flags and irq
module fpu_result_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = fpu_pkg::FPU_TAG_W
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       res_valid,
    input  logic [31:0]                res_data,
    input  logic [4:0]                 res_exc,
    input  logic [TAG_W-1:0]           res_tag,
    input  logic                       res_illegal,
    input  logic                       pop,
    input  logic                       clr_flags,
    input  logic                       irq_en,
    output logic [31:0]                head_data,
    output logic [4:0]                 head_exc,
    output logic [TAG_W-1:0]           head_tag,
    output logic                       head_illegal,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic [4:0]                 fflags,
    output logic                       overflow,
    output logic                       irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + TAG_W + 5 + 32;

    logic          trig, trig_q;
    logic          push_req, push_ok, pop_ok;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    fflags_q, fflags_d, entry_exc;
    logic          overflow_q, overflow_d, irq_q, irq_d;
    logic [EW-1:0] wr_entry, rd_entry;

    // An illegal op is captured like a result; one entry per rising edge of either
    assign trig = res_valid | res_illegal;

    rvdff #(.WIDTH(1)) u_trig_ff (.clk(clk), .rst_l(rst_l), .din(trig), .dout(trig_q));

    assign push_req = trig & ~trig_q;
    assign pop_ok   = pop & ~empty;
    // At full a same-cycle pop frees the slot being written (wr_ptr == rd_ptr)
    assign push_ok  = push_req & (~full | pop);

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Illegal entries carry no result or exceptions
    assign entry_exc = res_illegal ? 5'd0 : res_exc;
    assign wr_entry  = {res_illegal, res_tag, entry_exc, res_illegal ? 32'd0 : res_data};

    fpu_result_buf #(.DEPTH(DEPTH), .W(EW), .PW(PW)) u_buf (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sticky flags: clear first so a same-cycle accepted push leaves only its own exceptions
    always_comb begin
        fflags_d   = (clr_flags ? 5'd0 : fflags_q) | (push_ok ? entry_exc : 5'd0);
        overflow_d = clr_flags ? 1'b0 : (overflow_q | (push_req & ~push_ok));
        irq_d      = irq_en & (count_d != '0);
    end

    rvdff #(.WIDTH(5)) u_fflags_ff   (.clk(clk), .rst_l(rst_l), .din(fflags_d),   .dout(fflags_q));
    rvdff #(.WIDTH(1)) u_overflow_ff (.clk(clk), .rst_l(rst_l), .din(overflow_d), .dout(overflow_q));
    rvdff #(.WIDTH(1)) u_irq_ff      (.clk(clk), .rst_l(rst_l), .din(irq_d),      .dout(irq_q));

    assign fflags   = fflags_q;
    assign overflow = overflow_q;
    assign irq      = irq_q;
    assign count    = count_q;

    assign {head_illegal, head_tag, head_exc, head_data} = empty ? '0 : rd_entry;

endmodule

// File: tb/tb_fpu_result_queue.sv
// tb/tb_fpu_result_queue.sv - scoreboard bench for fpu_result_queue
module tb_fpu_result_queue;
    import fpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = FPU_TAG_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_l, res_valid, res_illegal, pop, clr_flags, irq_en;
    logic [31:0]      res_data;
    logic [4:0]       res_exc;
    logic [TAG_W-1:0] res_tag;
    logic [31:0]      head_data;
    logic [4:0]       head_exc;
    logic [TAG_W-1:0] head_tag;
    logic             head_illegal, empty, full, overflow, irq;
    logic [2:0]       count;
    logic [4:0]       fflags;

    int vectors = 0;
    int miscompares = 0;
    fpu_result_t sb[$];
    fpu_result_t exp_e, got_e;

    fpu_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_l(rst_l), .res_valid(res_valid), .res_data(res_data),
        .res_exc(res_exc), .res_tag(res_tag), .res_illegal(res_illegal),
        .pop(pop), .clr_flags(clr_flags), .irq_en(irq_en),
        .head_data(head_data), .head_exc(head_exc), .head_tag(head_tag),
        .head_illegal(head_illegal), .empty(empty), .full(full), .count(count),
        .fflags(fflags), .overflow(overflow), .irq(irq)
    );

    // One-cycle result (or illegal) pulse followed by one idle cycle; models the expected entry
    task automatic pulse(input logic [31:0] d, input logic [4:0] e, input logic [TAG_W-1:0] t,
                         input logic ill, input logic do_pop, input logic accept);
        fpu_result_t x;
        res_data = d; res_exc = e; res_tag = t;
        res_valid = ~ill; res_illegal = ill; pop = do_pop;
        if (do_pop && sb.size() > 0) void'(sb.pop_front());
        if (accept) begin
            x.illegal = ill; x.tag = t;
            x.exc = ill ? 5'd0 : e; x.data = ill ? 32'd0 : d;
            sb.push_back(x);
        end
        @(negedge clk);
        res_valid = 1'b0; res_illegal = 1'b0; pop = 1'b0; clr_flags = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_one();
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0; res_valid = 0; res_illegal = 0; pop = 0; clr_flags = 0; irq_en = 1'b1;
        res_data = '0; res_exc = '0; res_tag = '0;
        repeat (2) @(negedge clk);
        vectors++; if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
            miscompares++; $display("FAIL reset_status: empty=%b full=%b count=%0d want 1 0 0", empty, full, count); end
        vectors++; if (irq !== 1'b0 || fflags !== 5'd0 || overflow !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: irq=%b fflags=%b ovf=%b want 0 00000 0", irq, fflags, overflow); end
        vectors++; if ({head_illegal, head_tag, head_exc, head_data} !== '0) begin
            miscompares++; $display("FAIL reset_head: got %h want 0", {head_illegal, head_tag, head_exc, head_data}); end
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_level_hold();
        fpu_result_t x;
        res_valid = 1'b1; res_data = 32'h3F80_0000; res_exc = 5'b00001; res_tag = 13'h0101;
        x.illegal = 0; x.tag = 13'h0101; x.exc = 5'b00001; x.data = 32'h3F80_0000;
        sb.push_back(x);
        @(negedge clk);
        vectors++; if (head_data !== 32'h3F80_0000 || count !== 3'd1) begin
            miscompares++; $display("FAIL level_first: head_data=%h count=%0d want 3f800000 1", head_data, count); end
        vectors++; if (fflags !== 5'b00001 || irq !== 1'b1) begin
            miscompares++; $display("FAIL level_flags: fflags=%b irq=%b want 00001 1", fflags, irq); end
        repeat (4) @(negedge clk);
        res_valid = 1'b0;
        @(negedge clk);
        vectors++; if (count !== 3'd1) begin
            miscompares++; $display("FAIL level_single: count=%0d want 1", count); end
        irq_en = 1'b0;
        @(negedge clk);
        vectors++; if (irq !== 1'b0) begin
            miscompares++; $display("FAIL irq_disable: irq=%b want 0", irq); end
        irq_en = 1'b1;
        while (sb.size() > 0) begin
            exp_e = sb.pop_front(); got_e = {head_illegal, head_tag, head_exc, head_data};
            vectors++; if (got_e !== exp_e) begin
                miscompares++; $display("FAIL level_drain: got %h want %h", got_e, exp_e); end
            pop_one();
        end
        clr_flags = 1'b1; @(negedge clk); clr_flags = 1'b0;
        vectors++; if (fflags !== 5'd0 || empty !== 1'b1) begin
            miscompares++; $display("FAIL level_clear: fflags=%b empty=%b want 00000 1", fflags, empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++)
            pulse(32'h1000_0000 + i + 1, 5'(i), 13'(i + 1), 1'b0, 1'b0, i < DEPTH);
        vectors++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b1) begin
            miscompares++; $display("FAIL ovf_status: count=%0d full=%b ovf=%b want 4 1 1", count, full, overflow); end
        while (sb.size() > 0) begin
            exp_e = sb.pop_front(); got_e = {head_illegal, head_tag, head_exc, head_data};
            vectors++; if (got_e !== exp_e) begin
                miscompares++; $display("FAIL ovf_order: got %h want %h", got_e, exp_e); end
            pop_one();
        end
        vectors++; if (empty !== 1'b1 || count !== 3'd0 || {head_illegal, head_tag, head_exc, head_data} !== '0) begin
            miscompares++; $display("FAIL ovf_empty: empty=%b count=%0d head=%h want 1 0 0", empty, count,
                                    {head_illegal, head_tag, head_exc, head_data}); end
        clr_flags = 1'b1; @(negedge clk); clr_flags = 1'b0;
        vectors++; if (overflow !== 1'b0 || fflags !== 5'd0) begin
            miscompares++; $display("FAIL ovf_clear: ovf=%b fflags=%b want 0 00000", overflow, fflags); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++)
            pulse(32'hA000_0000 + i, 5'd0, 13'h0200 + 13'(i), 1'b0, 1'b0, 1'b1);
        exp_e = sb[0]; got_e = {head_illegal, head_tag, head_exc, head_data};
        vectors++; if (got_e !== exp_e) begin
            miscompares++; $display("FAIL full_head: got %h want %h", got_e, exp_e); end
        pulse(32'hA000_00FF, 5'd0, 13'h02FF, 1'b0, 1'b1, 1'b1);
        vectors++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
            miscompares++; $display("FAIL full_pushpop: count=%0d full=%b ovf=%b want 4 1 0", count, full, overflow); end
        while (sb.size() > 0) begin
            exp_e = sb.pop_front(); got_e = {head_illegal, head_tag, head_exc, head_data};
            vectors++; if (got_e !== exp_e) begin
                miscompares++; $display("FAIL full_order: got %h want %h", got_e, exp_e); end
            pop_one();
        end
    endtask

    task automatic test_illegal();
        pulse(32'hDEAD_BEEF, 5'b11111, 13'h1ABC, 1'b1, 1'b0, 1'b1);
        vectors++; if (head_illegal !== 1'b1 || head_data !== 32'd0 || head_exc !== 5'd0 || head_tag !== 13'h1ABC) begin
            miscompares++; $display("FAIL illegal_entry: ill=%b data=%h exc=%b tag=%h want 1 0 0 1abc",
                                    head_illegal, head_data, head_exc, head_tag); end
        vectors++; if (fflags !== 5'd0) begin
            miscompares++; $display("FAIL illegal_fflags: fflags=%b want 00000", fflags); end
        void'(sb.pop_front());
        pop_one();
    endtask

    task automatic test_fflags();
        pulse(32'h1, 5'(1 << EXC_NV), 13'h11, 1'b0, 1'b0, 1'b1);
        pulse(32'h2, 5'(1 << EXC_OF), 13'h12, 1'b0, 1'b0, 1'b1);
        vectors++; if (fflags !== 5'b10100) begin
            miscompares++; $display("FAIL fflags_accum: fflags=%b want 10100", fflags); end
        clr_flags = 1'b1;
        pulse(32'h3, 5'(1 << EXC_UF), 13'h13, 1'b0, 1'b0, 1'b1);
        vectors++; if (fflags !== 5'b00010 || overflow !== 1'b0 || count !== 3'd3) begin
            miscompares++; $display("FAIL fflags_clr_push: fflags=%b ovf=%b count=%0d want 00010 0 3", fflags, overflow, count); end
        while (sb.size() > 0) begin
            exp_e = sb.pop_front(); got_e = {head_illegal, head_tag, head_exc, head_data};
            vectors++; if (got_e !== exp_e) begin
                miscompares++; $display("FAIL fflags_drain: got %h want %h", got_e, exp_e); end
            pop_one();
        end
    endtask

    task automatic test_empty_pop_and_reset();
        pop_one();
        vectors++; if (count !== 3'd0 || empty !== 1'b1) begin
            miscompares++; $display("FAIL pop_empty: count=%0d empty=%b want 0 1", count, empty); end
        pulse(32'h5555_0001, 5'd0, 13'h21, 1'b0, 1'b1, 1'b1);
        vectors++; if (count !== 3'd1 || head_data !== 32'h5555_0001) begin
            miscompares++; $display("FAIL pushpop_empty: count=%0d data=%h want 1 55550001", count, head_data); end
        void'(sb.pop_front());
        pop_one();
        for (int i = 0; i < 3; i++)
            pulse(32'h7700_0000 + i, 5'b01000, 13'h30 + 13'(i), 1'b0, 1'b0, 1'b1);
        vectors++; if (count !== 3'd3) begin
            miscompares++; $display("FAIL prereset_fill: count=%0d want 3", count); end
        #3 rst_l = 1'b0;
        #1;
        vectors++; if (count !== 3'd0 || empty !== 1'b1 || fflags !== 5'd0) begin
            miscompares++; $display("FAIL async_reset: count=%0d empty=%b fflags=%b want 0 1 00000", count, empty, fflags); end
        sb.delete();
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        pulse(32'h8888_0001, 5'd0, 13'h41, 1'b0, 1'b0, 1'b1);
        exp_e = sb.pop_front(); got_e = {head_illegal, head_tag, head_exc, head_data};
        vectors++; if (count !== 3'd1 || got_e !== exp_e) begin
            miscompares++; $display("FAIL post_reset: count=%0d head=%h want 1 %h", count, got_e, exp_e); end
        pop_one();
        vectors++; if (empty !== 1'b1) begin
            miscompares++; $display("FAIL final_empty: empty=%b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_level_hold();
        test_overflow();
        test_full_push_pop();
        test_illegal();
        test_fflags();
        test_empty_pop_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
